// File: rtl/prbs_pkg.sv
// Shared constants for the two-lane PRBS7 checker: taps, default thresholds,
// accumulator widths and the lane state encoding.
package prbs_pkg;

    localparam int TAP_HI = 6;
    localparam int TAP_LO = 5;

    localparam int LOCK_RUN_DEF   = 64;
    localparam int ERR_THRESH_DEF = 8;
    localparam int WIN_LEN_DEF    = 256;

    localparam int RECV_CNT_W = 58;
    localparam int ERR_CNT_W  = 64;

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // x^7 + x^6 + 1: next bit is the XOR of the bits seen 7 and 6 cycles ago.
    function automatic logic prbs7_predict(input logic [6:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction

endpackage

// File: rtl/prbs_lane_sync.sv
// One PRBS7 lane: hunts for a self-consistent run, then free-runs its own
// generator and flags every bit that disagrees with the incoming stream.
module prbs_lane_sync
    import prbs_pkg::*;
#(
    parameter int LOCK_RUN   = LOCK_RUN_DEF,
    parameter int ERR_THRESH = ERR_THRESH_DEF,
    parameter int WIN_LEN    = WIN_LEN_DEF
) (
    input  logic clk,
    input  logic rstx,
    input  logic din_q,
    output logic lock,
    output logic err
);
    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int WIN_W  = $clog2(WIN_LEN);
    localparam int WERR_W = $clog2(ERR_THRESH + 1);

    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(LOCK_RUN - 1);
    localparam logic [WERR_W-1:0] ERR_TGT  = WERR_W'(ERR_THRESH);

    logic [0:0]        state_q, state_d;
    logic [6:0]        s_q, s_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0] win_err_q, win_err_d;

    logic              pred;
    logic              mismatch;
    logic [WERR_W-1:0] win_err_inc;

    always_comb begin
        pred        = prbs7_predict(s_q);
        mismatch    = (pred != din_q);
        win_err_inc = win_err_q + WERR_W'(mismatch);
        state_d     = state_q;
        s_d         = s_q;
        run_d       = run_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;

        if (state_q == ST_HUNT) begin
            s_d = {s_q[5:0], din_q};
            // An all-zero history predicts 0 forever, so it is never a match.
            if (!mismatch && (s_q != 7'd0)) begin
                if (run_q == RUN_LAST) begin
                    state_d   = ST_LOCK;
                    run_d     = '0;
                    win_cnt_d = '0;
                    win_err_d = '0;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end else begin
                run_d = '0;
            end
        end else begin
            // Free-running so a single corrupted input bit costs exactly one error.
            s_d = {s_q[5:0], pred};
            if (win_err_inc >= ERR_TGT) begin
                state_d   = ST_HUNT;
                run_d     = '0;
                win_cnt_d = '0;
                win_err_d = '0;
            end else begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
                win_err_d = (win_cnt_q == '1) ? '0 : win_err_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstx) begin
            state_q   <= ST_HUNT;
            s_q       <= '0;
            run_q     <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            run_q     <= run_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end

    assign lock = (state_q == ST_LOCK);
    assign err  = lock & mismatch;

endmodule

// File: rtl/prbs_checker.sv
// Two-lane PRBS7 checker: registers DIN, runs one lane synchroniser per bit
// and accumulates saturating received-bit and error totals while locked.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_RUN   = LOCK_RUN_DEF,
    parameter int ERR_THRESH = ERR_THRESH_DEF,
    parameter int WIN_LEN    = WIN_LEN_DEF,
    parameter int RECV_W     = RECV_CNT_W,
    parameter int ERR_W      = ERR_CNT_W
) (
    input  logic              CLK,
    input  logic              RSTX,
    input  logic              CLR,
    input  logic [1:0]        DIN,
    output logic [1:0]        LOCK,
    output logic [RECV_W-1:0] RECV_CNT,
    output logic [ERR_W-1:0]  ERR_CNT
);
    logic [1:0]        din_q, din_d;
    logic [1:0]        lane_lock;
    logic [1:0]        lane_err;
    logic [1:0]        recv_inc_q, recv_inc_d;
    logic [1:0]        err_inc_q, err_inc_d;
    logic [RECV_W-1:0] recv_cnt_q, recv_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [RECV_W:0]   recv_sum;
    logic [ERR_W:0]    err_sum;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            prbs_lane_sync #(
                .LOCK_RUN   (LOCK_RUN),
                .ERR_THRESH (ERR_THRESH),
                .WIN_LEN    (WIN_LEN)
            ) u_lane (
                .clk   (CLK),
                .rstx  (RSTX),
                .din_q (din_q[gi]),
                .lock  (lane_lock[gi]),
                .err   (lane_err[gi])
            );
        end
    endgenerate

    // Per-lane results are staged once before accumulation, so an error
    // sampled into din_q at edge n reaches ERR_CNT at edge n+2.
    always_comb begin
        din_d      = DIN;
        recv_inc_d = {1'b0, lane_lock[0]} + {1'b0, lane_lock[1]};
        err_inc_d  = {1'b0, lane_err[0]} + {1'b0, lane_err[1]};
        recv_sum   = {1'b0, recv_cnt_q} + {{(RECV_W-1){1'b0}}, recv_inc_q};
        err_sum    = {1'b0, err_cnt_q} + {{(ERR_W-1){1'b0}}, err_inc_q};

        if (CLR) begin
            recv_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            recv_cnt_d = recv_sum[RECV_W] ? '1 : recv_sum[RECV_W-1:0];
            err_cnt_d  = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTX) begin
            din_q      <= '0;
            recv_inc_q <= '0;
            err_inc_q  <= '0;
            recv_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            din_q      <= din_d;
            recv_inc_q <= recv_inc_d;
            err_inc_q  <= err_inc_d;
            recv_cnt_q <= recv_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign LOCK     = lane_lock;
    assign RECV_CNT = recv_cnt_q;
    assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker against a bit-history reference model;
// a second instance with 4-bit counters exercises saturation.
module tb_prbs_checker;
    localparam int LOCK_RUN   = 64;
    localparam int ERR_THRESH = 8;
    localparam int WIN_LEN    = 256;
    localparam longint unsigned NARROW_MAX = 15;

    logic        clk = 1'b0;
    logic        rstx;
    logic        clr;
    logic [1:0]  din;
    logic [1:0]  lock, lock_n;
    logic [57:0] recv_cnt;
    logic [63:0] err_cnt;
    logic [3:0]  recv_cnt_n, err_cnt_n;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    always #5 clk = ~clk;

    prbs_checker dut (
        .CLK(clk), .RSTX(rstx), .CLR(clr), .DIN(din),
        .LOCK(lock), .RECV_CNT(recv_cnt), .ERR_CNT(err_cnt)
    );

    prbs_checker #(.RECV_W(4), .ERR_W(4)) dut_n (
        .CLK(clk), .RSTX(rstx), .CLR(clr), .DIN(din),
        .LOCK(lock_n), .RECV_CNT(recv_cnt_n), .ERR_CNT(err_cnt_n)
    );

    // Reference model: per lane, the sequence the lane believes in (age 0 = newest).
    bit              m_hist [2][7];
    bit              m_locked [2];
    int              m_run [2];
    int              m_wpos [2];
    int              m_werr [2];
    logic [1:0]      m_dinq;
    longint unsigned m_recv, m_err;
    int              m_pend_recv, m_pend_err;

    logic [6:0] gen_s [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < 7; a++) m_hist[l][a] = 1'b0;
            m_locked[l] = 1'b0;
            m_run[l] = 0;
            m_wpos[l] = 0;
            m_werr[l] = 0;
        end
        m_dinq = '0;
        m_recv = 0;
        m_err = 0;
        m_pend_recv = 0;
        m_pend_err = 0;
    endtask

    task automatic hist_push(input int l, input bit b);
        for (int a = 6; a > 0; a--) m_hist[l][a] = m_hist[l][a-1];
        m_hist[l][0] = b;
    endtask

    task automatic model_edge();
        bit pred, seen, bad, nz;
        int errs;
        if (!rstx) begin
            model_reset();
            return;
        end
        if (clr) begin
            m_recv = 0;
            m_err = 0;
        end else begin
            m_recv += longint'(m_pend_recv);
            m_err  += longint'(m_pend_err);
        end
        m_pend_recv = 0;
        m_pend_err = 0;
        for (int l = 0; l < 2; l++) begin
            pred = m_hist[l][6] ^ m_hist[l][5];
            seen = m_dinq[l];
            if (m_locked[l]) begin
                bad = (pred != seen);
                m_pend_recv++;
                if (bad) m_pend_err++;
                errs = m_werr[l] + (bad ? 1 : 0);
                hist_push(l, pred);
                if (errs >= ERR_THRESH) begin
                    m_locked[l] = 1'b0;
                    m_run[l] = 0;
                end else begin
                    m_wpos[l] = (m_wpos[l] + 1) % WIN_LEN;
                    m_werr[l] = (m_wpos[l] == 0) ? 0 : errs;
                end
            end else begin
                nz = 1'b0;
                for (int a = 0; a < 7; a++) nz |= m_hist[l][a];
                hist_push(l, seen);
                m_run[l] = (nz && pred == seen) ? m_run[l] + 1 : 0;
                if (m_run[l] == LOCK_RUN) begin
                    m_locked[l] = 1'b1;
                    m_run[l] = 0;
                    m_wpos[l] = 0;
                    m_werr[l] = 0;
                end
            end
        end
        m_dinq = din;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        n_cyc++;
        check_eq("lock", 64'(lock), 64'({m_locked[1], m_locked[0]}));
        check_eq("recv_cnt", 64'(recv_cnt), m_recv);
        check_eq("err_cnt", err_cnt, m_err);
        check_eq("lock_n", 64'(lock_n), 64'({m_locked[1], m_locked[0]}));
        check_eq("recv_cnt_n", 64'(recv_cnt_n), (m_recv > NARROW_MAX) ? NARROW_MAX : m_recv);
        check_eq("err_cnt_n", 64'(err_cnt_n), (m_err > NARROW_MAX) ? NARROW_MAX : m_err);
    endtask

    task automatic prbs_cycle(input bit flip0, input bit flip1);
        logic [1:0] b;
        for (int l = 0; l < 2; l++) begin
            b[l] = gen_s[l][6] ^ gen_s[l][5];
            gen_s[l] = {gen_s[l][5:0], b[l]};
        end
        din = b ^ {flip1, flip0};
        tick();
    endtask

    task automatic report(input string name);
        $display("phase %-10s cycle=%0d lock=%b recv=%0d err=%0d recv_n=%0d err_n=%0d",
                 name, n_cyc, lock, recv_cnt, err_cnt, recv_cnt_n, err_cnt_n);
    endtask

    initial begin
        int lock_at;
        longint unsigned r0, e0;
        bit seen_lock;
        rstx = 1'b0;
        clr  = 1'b0;
        din  = '0;
        model_reset();

        repeat (4) begin
            din = 2'($urandom);
            tick();
        end
        check_eq("rst_lock", 64'(lock), 64'd0);
        check_eq("rst_recv", 64'(recv_cnt), 64'd0);
        check_eq("rst_err", err_cnt, 64'd0);
        report("reset");

        // Clean PRBS7 on both lanes from seed 7F.
        rstx = 1'b1;
        gen_s[0] = 7'h7F;
        gen_s[1] = 7'h7F;
        lock_at = -1;
        for (int c = 0; c < 72; c++) begin
            prbs_cycle(1'b0, 1'b0);
            if (lock_at < 0 && lock == 2'b11) lock_at = c;
        end
        check_eq("lock_within_72", 64'(lock_at >= 0), 64'd1);
        repeat (4) prbs_cycle(1'b0, 1'b0);
        r0 = recv_cnt;
        repeat (20) prbs_cycle(1'b0, 1'b0);
        check_eq("recv_rate", recv_cnt - r0, 64'd40);
        check_eq("clean_err", err_cnt, 64'd0);
        report("acquire");

        // Single lane0 flip: visible exactly two edges after sampling.
        e0 = err_cnt;
        prbs_cycle(1'b1, 1'b0);
        prbs_cycle(1'b0, 1'b0);
        check_eq("err_not_early", err_cnt, e0);
        prbs_cycle(1'b0, 1'b0);
        check_eq("err_plus_one", err_cnt, e0 + 1);
        check_eq("lock_kept", 64'(lock), 64'd3);
        report("flip0");

        // Eight lane1 flips inside one window drop lane1 only.
        for (int w = 0; w < 300 && m_wpos[1] > 40; w++) prbs_cycle(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            prbs_cycle(1'b0, 1'b1);
            if (k < 7) repeat ($urandom_range(1, 20)) prbs_cycle(1'b0, 1'b0);
        end
        prbs_cycle(1'b0, 1'b0);
        check_eq("lane1_dropped", 64'(lock), 64'd1);
        lock_at = -1;
        for (int c = 0; c < 80 && lock_at < 0; c++) begin
            prbs_cycle(1'b0, 1'b0);
            if (lock == 2'b11) lock_at = c;
        end
        check_eq("lane1_relock", 64'(lock_at >= 0), 64'd1);
        report("drop1");

        // CLR coinciding with a counted error.
        prbs_cycle(1'b1, 1'b0);
        prbs_cycle(1'b0, 1'b0);
        clr = 1'b1;
        prbs_cycle(1'b0, 1'b0);
        clr = 1'b0;
        check_eq("clr_recv", 64'(recv_cnt), 64'd0);
        check_eq("clr_err", err_cnt, 64'd0);
        check_eq("clr_lock", 64'(lock), 64'd3);
        report("clear");

        // Saturation of the 4-bit instance.
        repeat (4) begin
            prbs_cycle(1'b1, 1'b1);
            repeat (3) prbs_cycle(1'b0, 1'b0);
        end
        repeat (WIN_LEN) prbs_cycle(1'b0, 1'b0);
        repeat (4) begin
            prbs_cycle(1'b1, 1'b1);
            repeat (3) prbs_cycle(1'b0, 1'b0);
        end
        check_eq("sat_recv_n", 64'(recv_cnt_n), 64'd15);
        check_eq("sat_err_n", 64'(err_cnt_n), 64'd15);
        check_eq("sat_lock", 64'(lock), 64'd3);
        report("saturate");

        // Reset while locked, then reacquire.
        rstx = 1'b0;
        prbs_cycle(1'b0, 1'b0);
        check_eq("midrst_lock", 64'(lock), 64'd0);
        rstx = 1'b1;
        lock_at = -1;
        for (int c = 0; c < 80 && lock_at < 0; c++) begin
            prbs_cycle(1'b0, 1'b0);
            if (lock == 2'b11) lock_at = c;
        end
        check_eq("midrst_relock", 64'(lock_at >= 0), 64'd1);
        report("midreset");

        // Noisy PRBS with occasional CLR.
        for (int c = 0; c < 400; c++) begin
            clr = ($urandom_range(0, 49) == 0);
            prbs_cycle($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
        end
        clr = 1'b0;
        report("noisy");

        // Pure random data.
        for (int c = 0; c < 100; c++) begin
            din = 2'($urandom);
            tick();
        end
        report("random");

        // Constant zero stream never locks.
        rstx = 1'b0;
        din = '0;
        tick();
        rstx = 1'b1;
        seen_lock = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            din = 2'b00;
            tick();
            if (lock != 2'b00 || recv_cnt != '0 || err_cnt != '0) seen_lock = 1'b1;
        end
        check_eq("zeros_idle", 64'(seen_lock), 64'd0);
        report("zeros");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_RUN, default 64: consecutive good predictions required for a lane to enter LOCK.
REQ-002 Parameter ERR_THRESH, default 8: errors within one window that force a lane from LOCK back to HUNT.
REQ-003 Parameter WIN_LEN, default 256: error-window length in cycles, a power of two.
REQ-004 CLK  in  1  single clock; all logic SHALL be rising-edge on CLK.
REQ-005 RSTX  in  1  reset; synchronous, active-low.
REQ-006 CLR  in  1  synchronous clear of RECV_CNT and ERR_CNT.
REQ-007 DIN  in  2  serial PRBS7 data, one bit per lane per cycle, lane0 = DIN[0].
REQ-008 LOCK  out  2  per-lane lock status.
REQ-009 RECV_CNT  out  58  bits received while locked, summed over both lanes.
REQ-010 ERR_CNT  out  64  bit errors detected while locked, summed over both lanes.

Function
REQ-011 DIN SHALL be registered once (din_q) before any comparison; all lane logic SHALL operate on din_q.
REQ-012 Each lane SHALL hold a 7-bit state s; predicted bit p = s[6] XOR s[5] (x^7+x^6+1).
REQ-013 Lane FSM states SHALL be HUNT and LOCK only; reset state HUNT.
REQ-014 HUNT: s <= {s[5:0], din_q}; match = (p == din_q) AND (s != 0); a match increments run counter, a mismatch clears it.
REQ-015 HUNT -> LOCK when the run counter reaches LOCK_RUN; the run counter, window counter and window error count SHALL clear on entry.
REQ-016 All-zero state SHALL never count as a match, so a constant-0 stream never locks.
REQ-017 LOCK: s <= {s[5:0], p} (free-running, independent of din_q), so one flipped input bit yields exactly one error.
REQ-018 LOCK: err = (p != din_q); the window counter increments every cycle and wraps at WIN_LEN, clearing the window error count on wrap.
REQ-019 LOCK -> HUNT when the window error count, including the current error, reaches ERR_THRESH; the state register SHALL reseed from din_q in HUNT.
REQ-020 LOCK[i] SHALL be high exactly while lane i is in LOCK.
REQ-021 Per cycle, RECV_CNT SHALL add the number of locked lanes (0..2) and ERR_CNT SHALL add the number of locked lanes with err (0..2); each SHALL saturate at all-ones.
REQ-022 Latency: an error on DIN sampled at edge n SHALL be visible on ERR_CNT after edge n+2.
REQ-023 CLR SHALL take priority over a same-cycle increment (both counters become 0) and SHALL NOT affect LOCK or lane state.
REQ-024 The cycle that transitions LOCK -> HUNT SHALL still count its bit and error; the HUNT -> LOCK transition cycle SHALL NOT count.

Reset
REQ-025 While RSTX=0 at an edge: LOCK=0, RECV_CNT=0, ERR_CNT=0, din_q=0, all lane states=0, all FSMs=HUNT, all lane counters=0.
REQ-026 Reset asserted mid-LOCK SHALL drop LOCK on the same edge, and the lane SHALL fully reacquire afterward.

Structure
REQ-027 The PRBS7 tap positions, the defaults for LOCK_RUN, ERR_THRESH and WIN_LEN, the counter widths (58 and 64) and the HUNT/LOCK encoding SHALL live in a shared package, prbs_pkg.
REQ-028 Per-lane logic (s, FSM, run, window and window-error counters) SHALL be one sub-module, prbs_lane_sync, instantiated twice; counter accumulation stays in prbs_checker.

Verification
REQ-029 Reset: hold RSTX=0 for 4 cycles with random DIN -> LOCK=0, RECV_CNT=0, ERR_CNT=0.
REQ-030 Clean PRBS7 on both lanes (seed 7'h7F) -> LOCK=2'b11 within 72 cycles of data start; then RECV_CNT +2 per cycle and ERR_CNT stays 0.
REQ-031 Locked, flip a single lane0 bit -> ERR_CNT increases by exactly 1, two edges after sampling; LOCK stays 2'b11.
REQ-032 Locked, 8 lane1 flips within 200 cycles -> LOCK[1]=0 after the 8th error while LOCK[0] stays 1; LOCK[1] returns after 64 clean bits.
REQ-033 DIN=2'b00 held for 1000 cycles -> LOCK stays 0 and both counters stay 0.
REQ-034 Locked, CLR=1 in the same cycle an error counts -> both counters read 0 next cycle, LOCK unchanged; with counter widths overridden to 4 bits, saturation holds at 15.
